imem_boot_ctrl: RTL
===================

Name: imem_boot_ctrl

Overview:
- Sequences the instruction memory at boot.
- Receives a byte stream from the debug/UART link and assembles it into 32-bit words, little-endian. Writes those words sequentially into the instruction memory write port.
- Holds the core stalled until the program is loaded, then hands the read port to instruction fetch.
- Sits between the UART receiver, the core fetch stage and the instruction memory.

Parameters:
- DATA_WIDTH, 32, memory word width; must be 32.
- ADDR_WIDTH, 12, word-address width of the instruction memory; depth is 2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes during a load before an error.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- byte_valid  in  1  UART byte available
- byte_data  in  8  UART byte
- byte_ready  out  1  byte accepted when byte_valid && byte_ready
- boot_skip  in  1  in IDLE: bypass loading, go straight to RUN
- reload  in  1  in RUN: return to IDLE and stall core
- core_stall  out  1  hold core pipeline/PC
- load_err  out  1  sticky load error
- fetch_en  in  1  core fetch read enable
- fetch_addr  in  ADDR_WIDTH  core fetch word address
- fetch_data  out  DATA_WIDTH  instruction to core
- mem_re  out  1  to memory readEnable
- mem_raddr  out  ADDR_WIDTH  to memory readAddress
- mem_rdata  in  DATA_WIDTH  from memory readData (combinational read)
- mem_we  out  1  to memory writeEnable
- mem_waddr  out  ADDR_WIDTH  to memory writeAddress
- mem_wdata  out  DATA_WIDTH  to memory writeData

Behaviour:
- Reset values: state=IDLE, core_stall=1, load_err=0, mem_we=0, mem_waddr=0, mem_wdata=0, byte counter=0, word counter=0, timeout counter=0.
- States: IDLE, HDR1, LOAD, RUN, ERR (plus CHK with the optional feature).
- byte_ready=1 in IDLE, HDR1, LOAD and CHK; byte_ready=0 in RUN and ERR.
- IDLE:
  - boot_skip=1 -> RUN next cycle. boot_skip has priority over a simultaneous byte, and that byte is not accepted.
  - Otherwise an accepted byte becomes count[7:0] -> HDR1.
- HDR1: an accepted byte becomes count[15:8], giving N words.
  - N=0 -> RUN.
  - N>2^ADDR_WIDTH -> ERR.
  - Otherwise -> LOAD.
- LOAD:
  - Bytes are accepted in order b0..b3; word = {b3,b2,b1,b0}.
  - On the cycle after b3 is accepted: mem_we=1 for exactly one cycle, mem_waddr=word index, mem_wdata=word.
  - Word index starts at 0 and increments after each write.
  - When the Nth word is written -> RUN; with CHECKSUM_EN -> CHK instead.
  - No address wrap is possible because N is bounded by the header check.
- Timeout: in HDR1, LOAD and CHK, the counter clears on every accepted byte and increments otherwise. On reaching TIMEOUT_CYCLES -> ERR.
- RUN:
  - core_stall=0 and mem_re=fetch_en.
  - mem_raddr=fetch_addr.
  - fetch_data=mem_rdata, purely combinational, zero added latency.
  - reload=1 -> IDLE next cycle, core_stall=1, counters cleared.
- Outside RUN: mem_re=0, fetch_data=0, core_stall=1.
- ERR: load_err=1, core_stall=1, mem_we=0. Only reset exits ERR; reload is ignored.
- mem_raddr is driven to fetch_addr in every state.
- Read and write never overlap: writes occur only outside RUN.
- Reset mid-load: returns immediately to IDLE and abandons any partial word. Memory contents already written are retained.
- reload in any state other than RUN is ignored.

Optional Feature:
- Macro IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every payload byte. Header bytes are excluded.
  - After the last word, state CHK accepts one checksum byte.
  - Byte equal to the sum -> RUN; mismatch -> ERR.
  - Timeout applies in CHK.
- Undefined: no CHK state and no checksum byte; the last word goes directly to RUN.

Test Plan:
- Reset (reset=0), then release -> core_stall=1, byte_ready=1, load_err=0, mem_we=0, state IDLE.
- Send 0x02,0x00, then 0x13,0x00,0x00,0x00, 0x93,0x00,0x10,0x00 -> two mem_we pulses: addr0=0x00000013, addr1=0x00100093. Then core_stall falls and fetch_addr=1 returns 0x00100093.
- Header 0x01,0x10 (N=4097, ADDR_WIDTH=12) -> ERR, load_err=1, byte_ready=0, core_stall stays 1.
- Header N=1, then 2 payload bytes, then silence for TIMEOUT_CYCLES (set to 16) -> load_err=1 on cycle 16, no mem_we.
- In RUN assert reload -> core_stall=1 next cycle. Reload N=1 word 0xDEADBEEF -> addr0 rewritten, RUN again.
- boot_skip=1 with byte_valid=1 in IDLE -> RUN, byte not accepted, no writes.
- With IMEM_BOOT_CHECKSUM_EN: N=1, bytes 0x01,0x02,0x03,0x04:
  - checksum 0x0A -> RUN.
  - checksum 0x0B -> ERR.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Boot-time loader: assembles UART bytes into 32-bit little-endian words, writes them to
// instruction memory, then hands the read port to fetch. Optional checksum: IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  boot_skip,
    input  logic                  reload,
    output logic                  core_stall,
    output logic                  load_err,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]   MAX_WORDS    = 17'd1 << ADDR_WIDTH;

`ifdef IMEM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_HDR1 = 3'd1, ST_LOAD = 3'd2, ST_RUN = 3'd3, ST_ERR = 3'd4, ST_CHK = 3'd5
    } state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    logic [7:0] sum_r;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_HDR1 = 3'd1, ST_LOAD = 3'd2, ST_RUN = 3'd3, ST_ERR = 3'd4
    } state_t;

    logic load_done_s;
`endif

    state_t                state_r, state_s;
    logic [7:0]            count_lo_r;
    logic [ADDR_WIDTH:0]   n_words_r;
    logic [ADDR_WIDTH:0]   word_cnt_r;
    logic [1:0]            byte_cnt_r;
    logic [23:0]           word_buf_r;
    logic [TW-1:0]         timeout_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_waddr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic                  load_err_r;
    logic                  byte_ready_s, take_s, timeout_hit_s, word_end_s, last_word_s;
    logic [15:0]           hdr_s;

    // Handshake and datapath-decoded conditions.
    always_comb begin
        byte_ready_s  = (state_r == ST_IDLE) || (state_r == ST_HDR1) || (state_r == ST_LOAD)
`ifdef IMEM_BOOT_CHECKSUM_EN
                        || (state_r == ST_CHK)
`endif
                        ;
        take_s        = byte_valid && byte_ready_s && !((state_r == ST_IDLE) && boot_skip);
        timeout_hit_s = (timeout_r == TIMEOUT_LAST) && !take_s;
        word_end_s    = (byte_cnt_r == 2'd3);
        last_word_s   = ((word_cnt_r + 1'b1) == n_words_r);
        hdr_s         = {byte_data, count_lo_r};
`ifndef IMEM_BOOT_CHECKSUM_EN
        load_done_s   = mem_we_r && (word_cnt_r == n_words_r);
`endif
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (boot_skip)   state_s = ST_RUN;
                else if (take_s) state_s = ST_HDR1;
                else             state_s = ST_IDLE;
            end
            ST_HDR1: begin
                if (take_s) begin
                    if (hdr_s == 16'd0)                  state_s = ST_RUN;
                    else if ({1'b0, hdr_s} > MAX_WORDS) state_s = ST_ERR;
                    else                                 state_s = ST_LOAD;
                end else if (timeout_hit_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_HDR1;
                end
            end
            ST_LOAD: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (take_s && word_end_s && last_word_s) state_s = ST_CHK;
`else
                // Leave only after the final write pulse so writes never overlap RUN.
                if (load_done_s)                          state_s = ST_RUN;
`endif
                else if (timeout_hit_s)                   state_s = ST_ERR;
                else                                      state_s = ST_LOAD;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (take_s)             state_s = (byte_data == sum_r) ? ST_RUN : ST_ERR;
                else if (timeout_hit_s) state_s = ST_ERR;
                else                    state_s = ST_CHK;
            end
`endif
            ST_RUN: begin
                if (reload) state_s = ST_IDLE;
                else        state_s = ST_RUN;
            end
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_ERR;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Header capture, word assembly, write pulse, timeout and error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_lo_r  <= 8'd0;
            n_words_r   <= '0;
            word_cnt_r  <= '0;
            byte_cnt_r  <= 2'd0;
            word_buf_r  <= 24'd0;
            timeout_r   <= '0;
            mem_we_r    <= 1'b0;
            mem_waddr_r <= '0;
            mem_wdata_r <= '0;
            load_err_r  <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_r       <= 8'd0;
`endif
        end else begin
            mem_we_r   <= 1'b0;
            load_err_r <= load_err_r || (state_s == ST_ERR);
            if (take_s || (state_r == ST_IDLE)) timeout_r <= '0;
            else                                timeout_r <= timeout_r + 1'b1;
            case (state_r)
                ST_IDLE: begin
                    byte_cnt_r <= 2'd0;
                    word_cnt_r <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    sum_r      <= 8'd0;
`endif
                    if (take_s) count_lo_r <= byte_data;
                    else        count_lo_r <= count_lo_r;
                end
                ST_HDR1: begin
                    if (take_s) n_words_r <= hdr_s[ADDR_WIDTH:0];
                    else        n_words_r <= n_words_r;
                end
                ST_LOAD: begin
                    if (take_s && (word_cnt_r != n_words_r)) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        sum_r      <= csum_add(sum_r, byte_data);
`endif
                        if (word_end_s) begin
                            mem_we_r    <= 1'b1;
                            mem_waddr_r <= word_cnt_r[ADDR_WIDTH-1:0];
                            mem_wdata_r <= {byte_data, word_buf_r};
                            word_cnt_r  <= word_cnt_r + 1'b1;
                        end else begin
                            word_buf_r  <= {byte_data, word_buf_r[23:8]};
                        end
                    end else begin
                        byte_cnt_r <= byte_cnt_r;
                    end
                end
                default: begin
                    byte_cnt_r <= byte_cnt_r;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_s;
    assign core_stall = (state_r != ST_RUN);
    assign load_err   = load_err_r;
    assign mem_re     = (state_r == ST_RUN) && fetch_en;
    assign mem_raddr  = fetch_addr;
    assign fetch_data = (state_r == ST_RUN) ? mem_rdata : '0;
    assign mem_we     = mem_we_r;
    assign mem_waddr  = mem_waddr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule
